pwm_fade_ctrl: RTL and testbench
================================

Name: pwm_fade_ctrl

Overview:
Sequencer that drives the compare input of a downstream pwm generator to produce a brightness/duty fade (triangle ramp). Updates compare only on PWM period boundaries (period_tick from the pwm counter wrap), so there are no mid-period duty glitches. Supports single-shot (up, down, off) and continuous loop modes, with a graceful stop.

Parameters:
CTR_LEN, 8, width of compare and the PWM counter
DWELL_LEN, 8, width of dwell counter (extra PWM periods held per step)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
period_tick  in  1  1-cycle pulse, PWM counter wrap
start  in  1  start request, sampled only in IDLE
stop  in  1  stop request, sampled only when busy
cfg_min  in  CTR_LEN  ramp floor
cfg_max  in  CTR_LEN  ramp ceiling
cfg_step  in  CTR_LEN  compare increment/decrement per step
cfg_dwell  in  DWELL_LEN  extra periods held at each value
cfg_loop  in  1  1 = continuous triangle, 0 = single shot
compare  out  CTR_LEN  registered duty value to pwm
busy  out  1  state != IDLE
done  out  1  1-cycle pulse on return to IDLE

Behaviour:
- Reset (rst=0, async): state IDLE, compare=0, busy=0, done=0, dwell_cnt=0, stop_pend=0, latched cfg=0.
- States: IDLE, UP, DOWN, FINISH.
- IDLE + start=1: latch cfg_* into internal regs; state->UP; first_pend=1. Compare is unchanged (0) until the next period_tick. stop is ignored in IDLE; start wins if both are high.
- start while busy: ignored. cfg_* changes after latch: no effect.
- Sanitising at latch: step=0 -> 1; min>max -> effective max=min.
- All compare/state updates occur only on cycles with period_tick=1. Between ticks, compare is stable.
- First tick after start: compare<=min, dwell_cnt<=dwell, first_pend=0.
- Later ticks (step event): if dwell_cnt!=0, decrement and hold compare. Otherwise apply the step and reload dwell_cnt<=dwell. With dwell=D, each value is held D+1 periods.
- UP step: sum computed in CTR_LEN+1 bits. If compare+step >= max: compare<=max, state->DOWN. Else compare<=compare+step.
- DOWN step: difference computed in CTR_LEN+1 bits, no wrap. If compare-step <= min: compare<=min, then loop=1 -> UP, loop=0 -> FINISH. Else compare<=compare-step.
- FINISH step event: compare<=0, state->IDLE, done=1.
- In a loop, min and max are each emitted once per turnaround; no duplicate value.
- stop while busy: sets stop_pend. At the next period_tick (including one in the same cycle as stop), regardless of dwell: compare<=0, state->IDLE, done=1, stop_pend=0.
- done asserts for exactly one clk after any return to IDLE. busy deasserts the same edge.
- Reset mid-operation: immediate return to reset values. No done pulse.

Test Plan:
- min=10,max=40,step=10,dwell=0,loop=0, start, then ticks every 16 clk -> compare 0 until tick1, then 10,20,30,40,30,20,10,0. done pulses at tick8; busy high from start until tick8.
- Same config with dwell=2 -> each value held 3 ticks (10,10,10,20,...). Final 0 and done at tick 22.
- min=0,max=255,step=100,loop=0 -> 0,100,200,255,155,55,0,0(done). No 8-bit wrap at either end.
- loop=1,min=20,max=60,step=20 -> 20,40,60,40,20,40,60,... Assert stop between ticks 5 and 6 -> compare=0 and done at tick 6; stop held in the same cycle as tick 9 of a new run takes effect at tick 9.
- Assert rst low mid-ramp (compare=30) -> compare=0, busy=0 immediately without clk. done stays 0. After release, start works normally.
- start pulses during a run, and cfg changes mid-run -> ignored, sequence unchanged. min=50,max=30 -> compare 50 each step, then 0 with done (loop=0). step=0 behaves as step=1.

Source files
------------

// File: rtl/pwm_fade_ctrl.sv
// Triangle-ramp sequencer for a pwm compare register.
// All compare/state changes land on period_tick so the pwm never sees a mid-period duty change.
module pwm_fade_ctrl #(
  parameter int unsigned CTR_LEN   = 8,
  parameter int unsigned DWELL_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 period_tick,
  input  logic                 start,
  input  logic                 stop,
  input  logic [CTR_LEN-1:0]   cfg_min,
  input  logic [CTR_LEN-1:0]   cfg_max,
  input  logic [CTR_LEN-1:0]   cfg_step,
  input  logic [DWELL_LEN-1:0] cfg_dwell,
  input  logic                 cfg_loop,
  output logic [CTR_LEN-1:0]   compare,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {StIdle, StUp, StDown, StFinish} state_e;

  state_e               state_q;
  logic [CTR_LEN-1:0]   min_q, max_q, step_q;
  logic [DWELL_LEN-1:0] dwell_q, dwell_cnt_q;
  logic                 loop_q, stop_pend_q, first_pend_q;

  // One extra bit so neither end of the ramp can wrap.
  logic [CTR_LEN:0] sum, diff;
  logic             hit_max, hit_min;

  always_comb begin
    sum     = {1'b0, compare} + {1'b0, step_q};
    diff    = {1'b0, compare} - {1'b0, step_q};
    hit_max = (sum >= {1'b0, max_q});
    hit_min = diff[CTR_LEN] || (diff[CTR_LEN-1:0] <= min_q);
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      compare      <= '0;
      done         <= 1'b0;
      min_q        <= '0;
      max_q        <= '0;
      step_q       <= '0;
      dwell_q      <= '0;
      loop_q       <= 1'b0;
      dwell_cnt_q  <= '0;
      stop_pend_q  <= 1'b0;
      first_pend_q <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == StIdle) begin
        if (start) begin
          min_q        <= cfg_min;
          max_q        <= (cfg_min > cfg_max) ? cfg_min : cfg_max;
          step_q       <= (cfg_step == '0) ? CTR_LEN'(1) : cfg_step;
          dwell_q      <= cfg_dwell;
          loop_q       <= cfg_loop;
          stop_pend_q  <= 1'b0;
          first_pend_q <= 1'b1;
          state_q      <= StUp;
        end
      end else if (period_tick && (stop || stop_pend_q)) begin
        // Graceful stop overrides any pending dwell.
        compare      <= '0;
        state_q      <= StIdle;
        done         <= 1'b1;
        stop_pend_q  <= 1'b0;
        first_pend_q <= 1'b0;
      end else begin
        if (stop) stop_pend_q <= 1'b1;
        if (period_tick) begin
          if (first_pend_q) begin
            compare      <= min_q;
            dwell_cnt_q  <= dwell_q;
            first_pend_q <= 1'b0;
          end else if (dwell_cnt_q != '0) begin
            dwell_cnt_q <= dwell_cnt_q - DWELL_LEN'(1);
          end else begin
            dwell_cnt_q <= dwell_q;
            case (state_q)
              StUp: begin
                if (hit_max) begin
                  compare <= max_q;
                  state_q <= StDown;
                end else begin
                  compare <= sum[CTR_LEN-1:0];
                end
              end
              StDown: begin
                if (hit_min) begin
                  compare <= min_q;
                  state_q <= loop_q ? StUp : StFinish;
                end else begin
                  compare <= diff[CTR_LEN-1:0];
                end
              end
              StFinish: begin
                compare <= '0;
                state_q <= StIdle;
                done    <= 1'b1;
              end
              default: state_q <= StIdle;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl: list-based ramp model checked every cycle, plus directed literal ticks.
module tb_pwm_fade_ctrl;

  localparam int GAP = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       period_tick = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] cfg_min = '0, cfg_max = '0, cfg_step = '0, cfg_dwell = '0;
  logic       cfg_loop = 1'b0;
  logic [7:0] compare;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  // Model state: per-tick compare values expanded from the configured ramp.
  int seq[$];
  int idx = 0;
  int m_cmp = 0;
  bit m_busy = 0, m_done = 0, m_pend = 0, m_loop = 0;

  int exp_q[$];
  int base[$];

  pwm_fade_ctrl #(.CTR_LEN(8), .DWELL_LEN(8)) dut (
    .clk(clk), .rst(rst), .period_tick(period_tick), .start(start), .stop(stop),
    .cfg_min(cfg_min), .cfg_max(cfg_max), .cfg_step(cfg_step), .cfg_dwell(cfg_dwell),
    .cfg_loop(cfg_loop), .compare(compare), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Ramp values from the rules: min, step up clamped to max, step down clamped to min.
  task automatic build_seq(input int mn, input int mx, input int st, input int dw, input bit lp);
    int v[$];
    int cur;
    seq.delete();
    if (st == 0) st = 1;
    if (mn > mx) mx = mn;
    v.push_back(mn);
    cur = mn;
    forever begin
      if (cur + st >= mx) begin v.push_back(mx); break; end
      cur += st;
      v.push_back(cur);
    end
    cur = mx;
    forever begin
      if (cur - st <= mn) begin v.push_back(mn); break; end
      cur -= st;
      v.push_back(cur);
    end
    if (!lp) begin
      foreach (v[i]) for (int r = 0; r <= dw; r++) seq.push_back(v[i]);
      seq.push_back(0);
    end else begin
      for (int r = 0; r <= dw; r++) seq.push_back(v[0]);
      while (seq.size() < 400)
        for (int i = 1; i < v.size(); i++)
          for (int r = 0; r <= dw; r++) seq.push_back(v[i]);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_cmp = 0; m_busy = 0; m_done = 0; m_pend = 0; idx = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          build_seq(int'(cfg_min), int'(cfg_max), int'(cfg_step), int'(cfg_dwell), cfg_loop);
          m_loop = cfg_loop; m_busy = 1; idx = 0; m_pend = 0;
        end
      end else begin
        if (stop) m_pend = 1;
        if (period_tick) begin
          if (m_pend) begin
            m_cmp = 0; m_busy = 0; m_done = 1; m_pend = 0;
          end else if (idx < seq.size()) begin
            m_cmp = seq[idx];
            if (!m_loop && idx == seq.size() - 1) begin m_busy = 0; m_done = 1; end
            idx++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("model compare", {24'd0, compare}, m_cmp);
      chk("model busy", {31'd0, busy}, {31'd0, m_busy});
      chk("model done", {31'd0, done}, {31'd0, m_done});
    end
  end

  task automatic start_run(input int mn, input int mx, input int st, input int dw, input bit lp);
    cfg_min = 8'(mn); cfg_max = 8'(mx); cfg_step = 8'(st); cfg_dwell = 8'(dw); cfg_loop = lp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start busy", {31'd0, busy}, 1);
    chk("start compare", {24'd0, compare}, 0);
    repeat (GAP) @(negedge clk);
  endtask

  task automatic do_tick(input string tag, input int exp, input bit exp_done, input bit with_stop);
    period_tick = 1'b1;
    stop = with_stop;
    @(negedge clk);
    period_tick = 1'b0;
    stop = 1'b0;
    chk({tag, " compare"}, {24'd0, compare}, exp);
    chk({tag, " done"}, {31'd0, done}, {31'd0, exp_done});
    repeat (GAP) @(negedge clk);
  endtask

  task automatic run_list(input string tag, input int vals[$]);
    foreach (vals[i]) do_tick(tag, vals[i], (i == vals.size() - 1), 1'b0);
    chk({tag, " busy end"}, {31'd0, busy}, 0);
    chk({tag, " done end"}, {31'd0, done}, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset compare", {24'd0, compare}, 0);
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset done", {31'd0, done}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    start_run(10, 40, 10, 0, 0);
    run_list("basic", '{10, 20, 30, 40, 30, 20, 10, 0});

    base = '{10, 20, 30, 40, 30, 20, 10};
    exp_q.delete();
    foreach (base[i]) repeat (3) exp_q.push_back(base[i]);
    exp_q.push_back(0);
    start_run(10, 40, 10, 2, 0);
    run_list("dwell", exp_q);

    start_run(0, 255, 100, 0, 0);
    run_list("fullrange", '{0, 100, 200, 255, 155, 55, 0, 0});

    start_run(20, 60, 20, 0, 1);
    base = '{20, 40, 60, 40, 20};
    foreach (base[i]) do_tick("loop", base[i], 1'b0, 1'b0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop pending busy", {31'd0, busy}, 1);
    chk("stop pending compare", {24'd0, compare}, 20);
    repeat (GAP) @(negedge clk);
    do_tick("loop stop", 0, 1'b1, 1'b0);
    start_run(20, 60, 20, 0, 1);
    base = '{20, 40, 60, 40, 20, 40, 60, 40};
    foreach (base[i]) do_tick("loop2", base[i], 1'b0, 1'b0);
    do_tick("loop2 stop", 0, 1'b1, 1'b1);
    chk("loop2 busy end", {31'd0, busy}, 0);

    start_run(10, 40, 10, 0, 0);
    base = '{10, 20, 30};
    foreach (base[i]) do_tick("prereset", base[i], 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("async rst compare", {24'd0, compare}, 0);
    chk("async rst busy", {31'd0, busy}, 0);
    chk("async rst done", {31'd0, done}, 0);
    @(negedge clk);
    chk("held rst done", {31'd0, done}, 0);
    rst = 1'b1;
    @(negedge clk);
    start_run(10, 40, 10, 0, 0);
    run_list("after reset", '{10, 20, 30, 40, 30, 20, 10, 0});

    start_run(10, 40, 10, 0, 0);
    do_tick("ignore", 10, 1'b0, 1'b0);
    do_tick("ignore", 20, 1'b0, 1'b0);
    cfg_min = 8'd0; cfg_max = 8'd200; cfg_step = 8'd1; cfg_loop = 1'b1; cfg_dwell = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (GAP) @(negedge clk);
    run_list("ignore", '{30, 40, 30, 20, 10, 0});

    start_run(50, 30, 5, 0, 0);
    run_list("min>max", '{50, 50, 50, 0});

    start_run(3, 6, 0, 0, 0);
    run_list("step0", '{3, 4, 5, 6, 5, 4, 3, 0});

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
